// File: rtl/heater_tx_pkg.sv
// Shared types and helpers for the heater PWM command transmitter.
package heater_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_ON  = 3'd1,
    WAIT_ON  = 3'd2,
    SEND_OFF = 3'd3,
    WAIT_OFF = 3'd4,
    DONE     = 3'd5
  } heater_tx_state_t;

  localparam int HEATER_CMD_W = 32;
  localparam logic [HEATER_CMD_W-1:0] HEATER_CMD_ON  = 32'd1;
  localparam logic [HEATER_CMD_W-1:0] HEATER_CMD_OFF = 32'd0;

  function automatic logic [31:0] clamp_u32(input logic [31:0] val, input logic [31:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/heater_pwm_tx_if.sv
// Command-word stream between the heater transmitter and the heater bank.
interface heater_pwm_tx_if #(
  parameter int C_DATA_WIDTH = 32
);
  logic                    tvalid;
  logic [C_DATA_WIDTH-1:0] tdata;
  logic                    tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter; expire fires in the last enabled cycle of a phase.
module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // Counter is always loaded before it is enabled, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expire = en && (count == CNT_W'(1));

endmodule

// File: rtl/heater_pwm_tx.sv
// Duty-cycled heater command transmitter (ON/OFF words over a stream).
// Optional handshake stall counter: define HEATER_PWM_TX_STALL_CNT_EN.
module heater_pwm_tx
  import heater_tx_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 32,
  parameter int MAX_RO_HEATERS = 5,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      cfg_on_num,
  input  logic [CNT_W-1:0] cfg_on_cycles,
  input  logic [CNT_W-1:0] cfg_off_cycles,
  input  logic [15:0]      cfg_periods,
  heater_pwm_tx_if.master  m,
  output logic [31:0]      ro_heater_on_num,
  output logic             busy,
  output logic             done,
  output logic [15:0]      periods_done,
  output logic [31:0]      stall_cycles
);

  heater_tx_state_t state, state_nxt;

  logic [CNT_W-1:0] on_cyc_q, off_cyc_q;
  logic [15:0]      periods_q;
  logic             stop_pending;
  logic             hs, abort, launch;
  logic             tmr_load, tmr_en, tmr_expire;
  logic [CNT_W-1:0] tmr_val;
  logic [15:0]      pd_inc;

  assign hs     = m.tvalid & m.tready;
  assign abort  = stop | stop_pending;
  assign launch = (state == IDLE) && start;
  assign pd_inc = (periods_done == 16'hFFFF) ? periods_done : periods_done + 16'd1;

  assign tmr_load = hs && ((state == SEND_ON) || (state == SEND_OFF));
  assign tmr_val  = (state == SEND_ON) ? on_cyc_q : off_cyc_q;
  assign tmr_en   = (state == WAIT_ON) || (state == WAIT_OFF);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SEND_ON;
      SEND_ON:  if (hs) state_nxt = abort ? SEND_OFF : WAIT_ON;
      WAIT_ON:  if (abort || tmr_expire) state_nxt = SEND_OFF;
      SEND_OFF: if (hs) state_nxt = abort ? DONE : WAIT_OFF;
      WAIT_OFF: begin
        if (abort) begin
          state_nxt = DONE;
        end else if (tmr_expire) begin
          state_nxt = ((periods_q != 16'd0) && (pd_inc == periods_q)) ? DONE : SEND_ON;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      m.tvalid         <= 1'b0;
      m.tdata          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      ro_heater_on_num <= '0;
      periods_done     <= '0;
      stop_pending     <= 1'b0;
    end else begin
      state    <= state_nxt;
      m.tvalid <= (state_nxt == SEND_ON) || (state_nxt == SEND_OFF);
      m.tdata  <= (state_nxt == SEND_ON) ? C_DATA_WIDTH'(HEATER_CMD_ON)
                                         : C_DATA_WIDTH'(HEATER_CMD_OFF);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == DONE);

      if (state_nxt == IDLE) begin
        stop_pending <= 1'b0;
      end else if (stop && (state != IDLE) && (state != DONE)) begin
        stop_pending <= 1'b1;
      end

      if (launch) begin
        ro_heater_on_num <= clamp_u32(cfg_on_num, 32'(MAX_RO_HEATERS));
        periods_done     <= '0;
      end else if ((state == WAIT_OFF) && tmr_expire && !abort) begin
        periods_done <= pd_inc;
      end
    end
  end

  // Run configuration; a zero phase length behaves as one cycle.
  always_ff @(posedge clk) begin
    if (launch) begin
      on_cyc_q  <= (cfg_on_cycles  == '0) ? CNT_W'(1) : cfg_on_cycles;
      off_cyc_q <= (cfg_off_cycles == '0) ? CNT_W'(1) : cfg_off_cycles;
      periods_q <= cfg_periods;
    end
  end

`ifdef HEATER_PWM_TX_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (launch) begin
      stall_cycles <= '0;
    end else if (m.tvalid && !m.tready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
